aes_round_ctrl: RTL

Sequencing controller for the iterative AES-128 datapath core. It accepts a start request, then drives `accept`, `rndNo` and the five stage enables (`enbSB`, `enbSR`, `enbMC`, `enbAR`, `enbKS`) for one initial key-add cycle, NR-1 full rounds and one final round. It then flags completion. It sits directly upstream of the core's control inputs; the testbench or top level talks to it through a start/done handshake.

---
 rtl/aes_pkg.sv | 19 +
 rtl/aes_round_ctrl_if.sv | 28 ++
 rtl/aes_round_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES core definitions: control FSM states and round-number sizing.
package aes_pkg;

    // Number of cipher rounds for AES-128.
    localparam int unsigned NR_AES128 = 10;

    // Width of the round number; also indexes the key-schedule rcon lookup.
    localparam int unsigned RND_W = 4;

    // Round controller states.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StInit  = 3'd1,
        StRound = 3'd2,
        StFinal = 3'd3,
        StDone  = 3'd4
    } aes_state_e;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Start/done handshake plus the stage-enable bus between the round controller and the core.
interface aes_round_ctrl_if #(
    parameter int unsigned RW = 4
);
    logic          start;
    logic          ready;
    logic          busy;
    logic          done;
    logic          accept;
    logic [RW-1:0] rndNo;
    logic          enbSB;
    logic          enbSR;
    logic          enbMC;
    logic          enbAR;
    logic          enbKS;

    // Requester side: issues start, observes status and core controls.
    modport master (
        output start,
        input  ready, busy, done, accept, rndNo, enbSB, enbSR, enbMC, enbAR, enbKS
    );

    // Controller side.
    modport slave (
        input  start,
        output ready, busy, done, accept, rndNo, enbSB, enbSR, enbMC, enbAR, enbKS
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Sequencing controller for the iterative AES-128 datapath: one key-add cycle, NR-1 full rounds,
// one final round without MixColumns, then a single-cycle done pulse. Outputs are Moore.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = NR_AES128,
    parameter int unsigned RW = RND_W
) (
    input  logic              clk,
    input  logic              rst,
    aes_round_ctrl_if.slave   bus
);

    aes_state_e    state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;

    logic          ready, busy, done, accept;
    logic [RW-1:0] rnd_no;
    logic          enb_sb, enb_sr, enb_mc, enb_ar, enb_ks;

    // State and round counter registers with asynchronous abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and output decode from registered state only.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        rnd_no  = '0;
        enb_sb  = 1'b0;
        enb_sr  = 1'b0;
        enb_mc  = 1'b0;
        enb_ar  = 1'b0;
        enb_ks  = 1'b0;

        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (bus.start) begin
                    state_d = StInit;
                end
            end
            StInit: begin
                // Initial AddRoundKey; key register loads cipher_key with KS bypassed.
                busy    = 1'b1;
                accept  = 1'b1;
                enb_ar  = 1'b1;
                cnt_d   = RW'(1);
                state_d = StRound;
            end
            StRound: begin
                busy   = 1'b1;
                rnd_no = cnt_q;
                enb_sb = 1'b1;
                enb_sr = 1'b1;
                enb_mc = 1'b1;
                enb_ar = 1'b1;
                enb_ks = 1'b1;
                // Saturate at NR so the counter can never wrap.
                if (cnt_q != RW'(NR)) begin
                    cnt_d = cnt_q + RW'(1);
                end
                if (cnt_q == RW'(NR - 1)) begin
                    state_d = StFinal;
                end
            end
            StFinal: begin
                busy    = 1'b1;
                rnd_no  = RW'(NR);
                enb_sb  = 1'b1;
                enb_sr  = 1'b1;
                enb_ar  = 1'b1;
                enb_ks  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                ready   = 1'b1;
                done    = 1'b1;
                state_d = bus.start ? StInit : StIdle;
            end
            default: begin
                // Illegal encoding: fall back to idle.
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.ready  = ready;
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.accept = accept;
    assign bus.rndNo  = rnd_no;
    assign bus.enbSB  = enb_sb;
    assign bus.enbSR  = enb_sr;
    assign bus.enbMC  = enb_mc;
    assign bus.enbAR  = enb_ar;
    assign bus.enbKS  = enb_ks;

endmodule
